input_frame_collector: RTL and testbench

Parametrised multi-player input front end: synchronises raw button pins, debounces them, and latches every press between frame boundaries so taps shorter than a frame are never lost. On each frame trigger it publishes a registered per-button {held, pressed} snapshot. Player logic consumes that snapshot. The block sits between the board pins and the per-player game logic and replaces the single-player 10-bit collector.

---
 rtl/input_frame_collector.sv | 101 ++++++++++
 tb/tb_input_frame_collector.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/input_frame_collector.sv
// Multi-player button front end: sync, optional debounce, press latching, per-frame {held, pressed} snapshot.
// Define INPUT_DEBOUNCE_EN to build the debounce filter; otherwise the filtered level is the synchronised pin.
module input_frame_collector #(
  parameter int CHANNELS        = 2,
  parameter int BUTTONS         = 5,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             trigger,
  input  logic [CHANNELS*BUTTONS-1:0]      buttons,
  output logic [2*CHANNELS*BUTTONS-1:0]    control_state,
  output logic                             state_valid,
  output logic                             any_activity
);
  localparam int N = CHANNELS * BUTTONS;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic [N-1:0] filtered;
  logic [N-1:0] filtered_d;
  logic [N-1:0] latch;
  logic [N-1:0] edges;
  logic [N-1:0] held;
  logic [N-1:0] pressed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
    end
  end

`ifdef INPUT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt [N];

  // Counter holds the number of mismatched cycles already seen; the D-th one flips the level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filtered <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync2[i] == filtered[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          filtered[i] <= sync2[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  assign filtered = sync2;
`endif

  assign edges = filtered & ~filtered_d;

  // A trigger both publishes and clears the latch, so an edge in that cycle lands in this snapshot only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filtered_d   <= '0;
      latch        <= '0;
      held         <= '0;
      pressed      <= '0;
      state_valid  <= 1'b0;
      any_activity <= 1'b0;
    end else begin
      filtered_d  <= filtered;
      state_valid <= trigger;
      if (trigger) begin
        held         <= filtered;
        pressed      <= latch | edges;
        any_activity <= |(latch | edges);
        latch        <= '0;
      end else begin
        latch <= latch | edges;
      end
    end
  end

  always_comb begin
    control_state = '0;
    for (int i = 0; i < N; i++) begin
      control_state[2*i+1] = held[i];
      control_state[2*i]   = pressed[i];
    end
  end
endmodule

// File: tb/tb_input_frame_collector.sv
// Directed bench for input_frame_collector: vector table of single-button presses plus hand-written corner sequences.
module tb_input_frame_collector;
  localparam int CH = 2;
  localparam int BT = 5;
  localparam int N  = CH * BT;
  localparam int W  = 2 * N;
  localparam int D  = 4;
`ifdef INPUT_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam int LAT = DB ? 2 + D : 2;

  logic         clk;
  logic         reset;
  logic         trigger;
  logic [N-1:0] buttons;
  logic [W-1:0] control_state;
  logic         state_valid;
  logic         any_activity;

  input_frame_collector #(
    .CHANNELS(CH),
    .BUTTONS(BT),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trigger(trigger),
    .buttons(buttons),
    .control_state(control_state),
    .state_valid(state_valid),
    .any_activity(any_activity)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int           idx;
    int           len;
    int           gap;
    logic [W-1:0] exp_state;
    logic         exp_any;
  } vec_t;

  vec_t vec [7];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    buttons = '0;
    trigger = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Caller sits on a negedge; trigger is sampled on the next posedge, results checked on the following negedge.
  task automatic snap();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec[0] = '{0,  10, 0,  20'h00003, 1'b1};
    vec[1] = '{9,  8,  10, 20'h40000, 1'b1};
    vec[2] = '{4,  2,  10, DB ? 20'h00000 : 20'h00100, !DB};
    vec[3] = '{5,  4,  10, 20'h00400, 1'b1};
    vec[4] = '{7,  3,  10, DB ? 20'h00000 : 20'h04000, !DB};
    vec[5] = '{1,  20, 0,  20'h0000C, 1'b1};
    vec[6] = '{6,  0,  10, 20'h00000, 1'b0};

    reset   = 1'b1;
    trigger = 1'b1;
    buttons = '1;
    #1;
    chk("reset_state", control_state, '0);
    chk("reset_valid", W'(state_valid), '0);
    chk("reset_any", W'(any_activity), '0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("reset_hold_state", control_state, '0);
      chk("reset_hold_valid", W'(state_valid), '0);
      chk("reset_hold_any", W'(any_activity), '0);
    end
    trigger = 1'b0;
    buttons = '0;
    reset   = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_reset();
      if (vec[i].len > 0) buttons = N'(1) << vec[i].idx;
      wait_n(vec[i].len);
      buttons = '0;
      wait_n(vec[i].gap);
      exp_q.push_back(vec[i].exp_state);
      snap();
      chk($sformatf("vec%0d_state", i), control_state, exp_q.pop_front());
      chk($sformatf("vec%0d_valid", i), W'(state_valid), W'(1));
      chk($sformatf("vec%0d_any", i), W'(any_activity), W'(vec[i].exp_any));
    end

    // Hold then a second trigger: held stays, pressed is not repeated.
    do_reset();
    buttons = 10'h001;
    wait_n(10);
    snap();
    chk("hold_state", control_state, 20'h00003);
    chk("hold_valid", W'(state_valid), W'(1));
    chk("hold_any", W'(any_activity), W'(1));
    wait_n(1);
    chk("hold_valid_drop", W'(state_valid), '0);
    chk("hold_state_kept", control_state, 20'h00003);
    wait_n(2);
    snap();
    chk("hold2_state", control_state, 20'h00002);
    chk("hold2_any", W'(any_activity), '0);
    chk("hold2_valid", W'(state_valid), W'(1));

    // Reset asserted between clock edges must clear outputs with no edge.
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_state", control_state, '0);
    chk("async_reset_any", W'(any_activity), '0);
    chk("async_reset_valid", W'(state_valid), '0);
    @(negedge clk);
    reset   = 1'b0;
    buttons = '0;

    // Filtered rising edge coincides with the trigger cycle.
    do_reset();
    buttons = 10'h004;
    wait_n(LAT);
    snap();
    chk("simul_state", control_state, 20'h00030);
    chk("simul_any", W'(any_activity), W'(1));
    wait_n(3);
    snap();
    chk("simul2_state", control_state, 20'h00020);
    chk("simul2_any", W'(any_activity), '0);

    // Button held across a reset pulse is detected again.
    do_reset();
    buttons = 10'h008;
    wait_n(10);
    snap();
    chk("midreset_pre_state", control_state, 20'h000C0);
    wait_n(2);
    snap();
    chk("midreset_pre2_state", control_state, 20'h00080);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_cleared", control_state, '0);
    wait_n(7);
    snap();
    chk("midreset_state", control_state, 20'h000C0);
    chk("midreset_any", W'(any_activity), W'(1));
    buttons = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
